// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Tracks every in-flight register write of the pipeline with a per-register,
// per-register-file latency countdown. From that state it decides, for the
// instruction currently in ID:
//   - where each source operand must be taken from in EX (register file,
//     EX/MEM or MEM/WB bypass),
//   - whether ID has to stall because a producer is still too far away
//     (load-use / multi-cycle latency) or because the new write would retire
//     before an older write to the same register (WAW),
//   - a saturating count of stalled cycles.
// The same structure covers 1-cycle ALU ops, 2-cycle loads and N-cycle FP ops.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   issue_valid / issue_flush ID holds an instruction / it is being flushed
//   issue_wr/_rf/_addr/_lat   destination of the issuing instruction and the
//                             number of cycles until it sits in EX/MEM
//   srcN_used/_rf/_addr       source operand N of the issuing instruction
//   stall                     hold IF/ID, inject a bubble into ID/EX
//   fwdN_sel                  00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_cnt                 saturating count of cycles with stall=1
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int NUM_RF   = 2,
    parameter int RF_W     = 1,
    parameter int LAT_W    = 4,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              issue_valid,
    input  logic              issue_flush,
    input  logic              issue_wr,
    input  logic [RF_W-1:0]   issue_rf,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [LAT_W-1:0]  issue_lat,
    input  logic              src1_used,
    input  logic [RF_W-1:0]   src1_rf,
    input  logic [ADDR_W-1:0] src1_addr,
    input  logic              src2_used,
    input  logic [RF_W-1:0]   src2_rf,
    input  logic [ADDR_W-1:0] src2_addr,
    output logic              stall,
    output logic [1:0]        fwd1_sel,
    output logic [1:0]        fwd2_sel,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int DEPTH     = 1 << ADDR_W;
    localparam int IDX_W     = RF_W + ADDR_W;
    localparam int NUM_ENT   = NUM_RF * DEPTH;
    // The table is allocated for every encodable (rf, addr) so that any index
    // is in range; entries of non-existent files are never loaded.
    localparam int ENT_ALLOC = 1 << IDX_W;

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------
    function automatic logic rf_ok(input logic [RF_W-1:0] rf);
        return int'(rf) < NUM_RF;
    endfunction

    function automatic logic is_zero_reg(input logic [RF_W-1:0]   rf,
                                         input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (rf == '0) && (addr == '0);
    endfunction

    // A zero latency would mean "already in EX/MEM before EX entry", which
    // cannot happen; the shortest real producer is one cycle.
    function automatic logic [LAT_W-1:0] eff_lat(input logic [LAT_W-1:0] lat);
        return (lat == '0) ? LAT_W'(1) : lat;
    endfunction

    // Returns {stall, sel} for one operand given its scoreboard entry.
    function automatic logic [2:0] classify(input logic             tracked,
                                            input logic             ent_valid,
                                            input logic [LAT_W-1:0] ent_rem);
        if (!tracked || !ent_valid) return {1'b0, SEL_RF};
        if (ent_rem == LAT_W'(1))   return {1'b0, SEL_EXMEM};
        if (ent_rem == '0)          return {1'b0, SEL_MEMWB};
        return {1'b1, SEL_RF};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    // -----------------------------------------------------------------------
    // Scoreboard state
    // -----------------------------------------------------------------------
    logic             sb_valid     [ENT_ALLOC];
    logic [LAT_W-1:0] sb_rem       [ENT_ALLOC];
    logic             sb_valid_nxt [ENT_ALLOC];
    logic [LAT_W-1:0] sb_rem_nxt   [ENT_ALLOC];

    // -----------------------------------------------------------------------
    // Lookup against the current (pre-update) state
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] dst_idx;
    logic [IDX_W-1:0] src1_idx;
    logic [IDX_W-1:0] src2_idx;
    logic             dst_track;
    logic             src1_track;
    logic             src2_track;
    logic [2:0]       src1_res;
    logic [2:0]       src2_res;
    logic             waw_hit;
    logic             issue_fire;

    assign dst_idx  = {issue_rf, issue_addr};
    assign src1_idx = {src1_rf, src1_addr};
    assign src2_idx = {src2_rf, src2_addr};

    assign dst_track  = rf_ok(issue_rf) && !is_zero_reg(issue_rf, issue_addr);
    assign src1_track = src1_used && rf_ok(src1_rf) && !is_zero_reg(src1_rf, src1_addr);
    assign src2_track = src2_used && rf_ok(src2_rf) && !is_zero_reg(src2_rf, src2_addr);

    assign src1_res = classify(src1_track, sb_valid[src1_idx], sb_rem[src1_idx]);
    assign src2_res = classify(src2_track, sb_valid[src2_idx], sb_rem[src2_idx]);

    // A younger write whose latency does not exceed the older writer's
    // remaining time would land first and then be overwritten by stale data.
    assign waw_hit = issue_valid && issue_wr && dst_track && sb_valid[dst_idx]
                     && (eff_lat(issue_lat) <= sb_rem[dst_idx]);

    // Flush wins over every stall source.
    assign stall = issue_valid && !issue_flush
                   && (src1_res[2] || src2_res[2] || waw_hit);

    assign issue_fire = issue_valid && issue_wr && !stall && !issue_flush && dst_track;

    assign fwd1_sel = src1_res[1:0];
    assign fwd2_sel = src2_res[1:0];

    // -----------------------------------------------------------------------
    // Next state: countdown / retire every live entry, then let the issuing
    // write take over its target entry.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < ENT_ALLOC; i++) begin
            sb_valid_nxt[i] = 1'b0;
            sb_rem_nxt[i]   = sb_rem[i];
            if (i < NUM_ENT) begin
                if (sb_valid[i] && (sb_rem[i] != '0)) begin
                    sb_valid_nxt[i] = 1'b1;
                    sb_rem_nxt[i]   = sb_rem[i] - LAT_W'(1);
                end
                if (issue_fire && (dst_idx == IDX_W'(i))) begin
                    sb_valid_nxt[i] = 1'b1;
                    sb_rem_nxt[i]   = eff_lat(issue_lat);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < ENT_ALLOC; i++) begin
                sb_valid[i] <= 1'b0;
                sb_rem[i]   <= '0;
            end
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < ENT_ALLOC; i++) begin
                sb_valid[i] <= sb_valid_nxt[i];
                sb_rem[i]   <= sb_rem_nxt[i];
            end
            if (stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

endmodule
